dmem_arbiter: RTL
=================

# dmem_arbiter

Two-master arbiter and sequencer for the single-port data SRAM (`sram_data`). Master 0 is the core load/store unit and master 1 is the debug/DMA loader. Each cycle it picks at most one request, drives the SRAM port from that request, and range-checks the word address. It registers the read data and returns a one-cycle response to the winning master. Fairness is round-robin, plus an optional bounded lock for atomic read-modify-write sequences.

## Interface
Parameters:
- NUM_WORDS, 10: SRAM depth in 32-bit words. Valid word addresses are 0..NUM_WORDS-1.
- LOCK_MAX, 8: maximum consecutive cycles a lock may be held, 1..255.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- m0_req_i / m1_req_i  in  1  access request.
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read.
- m0_addr_i / m1_addr_i  in  32  word address.
- m0_wdata_i / m1_wdata_i  in  32  write data.
- m0_lock_i / m1_lock_i  in  1  request or keep exclusive ownership after this access.
- m0_gnt_o / m1_gnt_o  out  1  access accepted this cycle (combinational).
- m0_rvalid_o / m1_rvalid_o  out  1  response valid, a one-cycle pulse.
- m0_rdata_o / m1_rdata_o  out  32  read data. 0 for writes and errors.
- m0_err_o / m1_err_o  out  1  address out of range, qualified by rvalid.
- sram_req_o  out  1  SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  32  SRAM word address.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM combinational read data for sram_addr_o.

## Operation
- An access is accepted when req && gnt. At most one gnt is high per cycle. gnt never asserts without req.
- Round-robin pointer last_q records the master granted most recently and resets to 1.
  - Both masters requesting: the master != last_q wins.
  - One master requesting: that master wins.
  - last_q updates on every accepted access.
- Lock FSM has three states: UNLOCKED, LOCK0, LOCK1.
  - UNLOCKED -> LOCKn when master n is granted with lock_i=1.
  - In LOCKn, only master n can be granted. The other master waits, even if master n is idle.
  - LOCKn -> UNLOCKED when master n is granted with lock_i=0.
  - LOCKn -> UNLOCKED when lock_cnt_q reaches LOCK_MAX-1 (forced release).
- lock_cnt_q counts cycles spent in LOCKn and clears on every transition.
  - On forced release: that cycle's grant follows the normal lock rules, and the next cycle arbitrates round-robin.
  - If master n is granted with lock_i=1 in the forced-release cycle, the FSM still goes to UNLOCKED and the lock is not re-acquired that cycle.
- Address range:
  - addr < NUM_WORDS: sram_req_o=1, sram_we_o=we, sram_addr_o=addr, sram_wdata_o=wdata, all from the winning master.
  - addr >= NUM_WORDS: still granted, but sram_req_o=0 and no SRAM write occurs. The response carries err=1.
- sram_addr_o, sram_we_o and sram_wdata_o are 0 when there is no grant.
- Response register:
  - Captures the winner id, err flag and data at the accept edge.
  - Data is sram_rdata_i for an in-range read, otherwise 0.
  - Only the winner's rvalid pulses. The other master's rdata_o and err_o are 0.

## Timing
- Grant latency is 0 cycles: gnt is combinational from req, the FSM state and last_q.
- Response latency is exactly 1 cycle after accept, for reads, writes and errors alike.
- Full throughput: one accepted access per cycle, with back-to-back responses.
- A write is visible to a read accepted in the next cycle.
- While rst_i=1:
  - all gnt outputs and sram_req_o are forced to 0;
  - at the next edge: rvalid=0, err=0, rdata=0, state=UNLOCKED, lock_cnt_q=0, last_q=1.
- Reset asserted in the cycle after an accept: the pending response is dropped, and rvalid stays 0.
- A request held without grant must not change until granted. The arbiter does not buffer requests.

## Structure
- Shared package dmem_arb_pkg holds:
  - the lock state encoding (UNLOCKED=2'd0, LOCK0=2'd1, LOCK1=2'd2);
  - the master id constants M_LSU=1'b0, M_DBG=1'b1;
  - the response width constants.
- One sub-module, dmem_arb_rr2: a two-way round-robin pick.
  - Inputs: req[1:0], last, force_en, force_id.
  - Outputs: one-hot gnt[1:0].
- The lock FSM, range check and response register stay in dmem_arbiter.

## Test plan
- Single read: m0 reads addr 3 with the SRAM holding 0x10 -> m0_gnt=1 the same cycle; next cycle m0_rvalid=1, m0_rdata=0x10, m0_err=0; m1 outputs 0.
- Contention: both masters request every cycle after reset -> grants alternate m0,m1,m0,m1; each rvalid follows its grant by 1 cycle.
- Write then read: m1 writes 0xDEADBEEF to addr 9, then reads addr 9 in the next cycle -> read returns 0xDEADBEEF.
- Out of range: m0 reads addr 10 -> sram_req_o=0; next cycle m0_rvalid=1, m0_err=1, rdata=0. A write to addr 12 leaves all 10 words unchanged.
- Lock:
  - m0 is granted with lock=1 while m1 requests continuously -> m1 gnt=0 until m0 is granted with lock=0, then m1 is granted the next cycle.
  - With m0 idle and still locked, LOCK_MAX=8 -> forced release after 8 cycles, and m1 is granted in cycle 9.
- Reset mid-operation: rst_i asserted the cycle after an accepted read -> no rvalid, FSM UNLOCKED, and the first post-reset contention grants m0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants and response record for the data SRAM arbiter
package dmem_arb_pkg;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCK0    = 2'd1;
  localparam logic [1:0] ST_LOCK1    = 2'd2;

  localparam logic M_LSU = 1'b0;
  localparam logic M_DBG = 1'b1;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic              valid;
    logic              id;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/dmem_arb_rr2.sv
// rtl/dmem_arb_rr2.sv - two-way round-robin pick with an optional forced owner
module dmem_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_id,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (force_en) begin
      // the locked owner alone may win, the other master waits even if the owner is idle
      gnt[force_id] = req[force_id];
    end else if (req == 2'b11) begin
      gnt[~last] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter, range check and response register for sram_data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_WORDS = 10,
  parameter int LOCK_MAX  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_lock_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_lock_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,
  output logic        sram_req_o,
  output logic        sram_we_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  input  logic [31:0] sram_rdata_i
);

  logic [1:0]        state_q, state_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              last_q, last_d;
  rsp_t              rsp_q, rsp_d;

  logic [1:0]        req, gnt;
  logic              locked, lock_id, accept, win_id;
  logic              win_we, win_lock, in_range, rsp_vis;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign req     = {m1_req_i, m0_req_i} & {2{~rst_i}};
  assign locked  = (state_q != ST_UNLOCKED);
  assign lock_id = (state_q == ST_LOCK1);

  dmem_arb_rr2 u_rr (
    .req      (req),
    .last     (last_q),
    .force_en (locked),
    .force_id (lock_id),
    .gnt      (gnt)
  );

  assign accept    = |gnt;
  assign win_id    = gnt[1];
  assign win_we    = win_id ? m1_we_i    : m0_we_i;
  assign win_addr  = win_id ? m1_addr_i  : m0_addr_i;
  assign win_wdata = win_id ? m1_wdata_i : m0_wdata_i;
  assign win_lock  = win_id ? m1_lock_i  : m0_lock_i;
  assign in_range  = (win_addr < ADDR_W'(NUM_WORDS));

  assign m0_gnt_o     = gnt[0];
  assign m1_gnt_o     = gnt[1];
  assign sram_req_o   = accept & in_range;
  assign sram_we_o    = accept & in_range & win_we;
  assign sram_addr_o  = accept ? win_addr  : '0;
  assign sram_wdata_o = accept ? win_wdata : '0;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_d     = accept ? win_id : last_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (accept && win_lock) begin
          state_d    = (win_id == M_DBG) ? ST_LOCK1 : ST_LOCK0;
          lock_cnt_d = 8'd0;
        end
      end
      default: begin
        // a forced release wins over a renewed lock request in the same cycle
        if ((lock_cnt_q == 8'(LOCK_MAX - 1)) || (accept && !win_lock)) begin
          state_d    = ST_UNLOCKED;
          lock_cnt_d = 8'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = accept;
    rsp_d.id    = win_id;
    rsp_d.err   = accept & ~in_range;
    rsp_d.data  = (accept && in_range && !win_we) ? sram_rdata_i : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_UNLOCKED;
      lock_cnt_q <= 8'd0;
      last_q     <= M_DBG;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      last_q     <= last_d;
      rsp_q      <= rsp_d;
    end
  end

  // a response pending when reset arrives is dropped immediately
  assign rsp_vis     = rsp_q.valid & ~rst_i;
  assign m0_rvalid_o = rsp_vis & (rsp_q.id == M_LSU);
  assign m1_rvalid_o = rsp_vis & (rsp_q.id == M_DBG);
  assign m0_rdata_o  = m0_rvalid_o ? rsp_q.data : '0;
  assign m1_rdata_o  = m1_rvalid_o ? rsp_q.data : '0;
  assign m0_err_o    = m0_rvalid_o & rsp_q.err;
  assign m1_err_o    = m1_rvalid_o & rsp_q.err;

endmodule
